// File: rtl/bin_to_bcd_if.sv
// Handshake and result bus between a binary count source and the bin_to_bcd converter.
// The master launches conversions; the converter (slave) reports busy/done and the packed BCD result.
interface bin_to_bcd_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Optional macro BIN2BCD_SATURATE_EN forces the result to all nines when the input overflows.
module bin_to_bcd #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic          clk,
  input  logic          rst,
  bin_to_bcd_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   work_bcd;
  logic               work_ovf;
  logic [CNT_W-1:0]   cnt;

  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W-1:0]   next_bcd;
  logic [BCD_W-1:0]   final_bcd;
  logic               final_ovf;

  // Per-nibble add-3 stays within 4 bits; the top bit of the adjusted top nibble is what shifts out.
  always_comb begin
    adj_bcd   = '0;
    next_bcd  = '0;
    final_bcd = '0;
    final_ovf = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_bcd[4*k +: 4] >= 4'd5)
        adj_bcd[4*k +: 4] = work_bcd[4*k +: 4] + 4'd3;
      else
        adj_bcd[4*k +: 4] = work_bcd[4*k +: 4];
    end
    next_bcd  = {adj_bcd[BCD_W-2:0], bin_sr[BIN_W-1]};
    final_ovf = work_ovf | adj_bcd[BCD_W-1];
`ifdef BIN2BCD_SATURATE_EN
    final_bcd = final_ovf ? {DIGITS{4'h9}} : next_bcd;
`else
    final_bcd = next_bcd;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      work_bcd <= '0;
      work_ovf <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr   <= bus.bin_in;
            work_bcd <= '0;
            work_ovf <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr   <= {bin_sr[BIN_W-2:0], 1'b0};
          work_bcd <= next_bcd;
          work_ovf <= final_ovf;
          cnt      <= cnt + CNT_W'(1);
          // The shift at count BIN_W-1 is the last one; publish the result on the same edge.
          if (cnt == CNT_W'(BIN_W - 1)) begin
            bcd_q  <= final_bcd;
            ovf_q  <= final_ovf;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized self-checking bench for bin_to_bcd against a decimal-arithmetic reference model.
// Honors BIN2BCD_SATURATE_EN the same way the design does when computing expected results.
module tb_bin_to_bcd;
  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int LAT    = BIN_W;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bin_to_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits of v mod 10^6, optionally saturated when v exceeds 999999.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned m;
    logic [23:0] r;
    m = v % 1000000;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BIN2BCD_SATURATE_EN
    if (v > 999999) r = 24'h999999;
`endif
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return (v > 999999);
  endfunction

  // Launches one conversion from idle and waits (bounded) for done, sampling 1ns after each edge.
  task automatic run_conv(input logic [BIN_W-1:0] v, output logic [23:0] bcd, output logic ovf,
                          output int lat, output int busy_cnt, output bit timeout);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 3 * LAT) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    timeout = !bus.done;
    bcd = bus.bcd_out;
    ovf = bus.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.bcd_out !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h expected all zero",
               bus.busy, bus.done, bus.overflow, bus.bcd_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [23:0] bcd; logic ovf; int lat, bc; bit to;
    run_conv('0, bcd, ovf, lat, bc, to);
    checks++;
    if (to || lat !== LAT) begin
      failures++;
      $display("[TB] FAIL zero_latency: got %0d cycles (timeout=%0d) expected %0d", lat, to, LAT);
    end
    checks++;
    if (bc !== LAT) begin
      failures++;
      $display("[TB] FAIL zero_busy_cycles: got %0d expected %0d", bc, LAT);
    end
    checks++;
    if (bcd !== 24'h000000 || ovf !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_result: bcd=%h ovf=%b busy=%b expected 000000/0/0", bcd, ovf, bus.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.bcd_out !== 24'h000000) begin
      failures++;
      $display("[TB] FAIL done_one_cycle: done=%b bcd=%h expected 0/000000", bus.done, bus.bcd_out);
    end
  endtask

  task automatic test_values();
    int unsigned vals [7] = '{123456, 999999, 9, 1000000, 1048575, 100000, 500000};
    logic [23:0] bcd; logic ovf; int lat, bc; bit to;
    foreach (vals[i]) begin
      run_conv(BIN_W'(vals[i]), bcd, ovf, lat, bc, to);
      checks++;
      if (to || bcd !== ref_bcd(vals[i]) || ovf !== ref_ovf(vals[i])) begin
        failures++;
        $display("[TB] FAIL value_%0d: bcd=%h ovf=%b timeout=%0d expected %h/%b",
                 vals[i], bcd, ovf, to, ref_bcd(vals[i]), ref_ovf(vals[i]));
      end
    end
    // Result registers hold between conversions.
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.bcd_out !== ref_bcd(500000) || bus.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_result: bcd=%h ovf=%b expected %h/0", bus.bcd_out, bus.overflow, ref_bcd(500000));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int done_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.bin_in = 20'd42;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 3 * LAT) begin
      if (cyc == 4) begin bus.start = 1'b1; bus.bin_in = 20'd77; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    checks++;
    if (!bus.done || cyc !== LAT || bus.bcd_out !== 24'h000042) begin
      failures++;
      $display("[TB] FAIL ignore_busy_start: done at %0d bcd=%h expected %0d/000042", cyc, bus.bcd_out, LAT);
    end
    // Start in the done cycle.
    bus.start = 1'b1; bus.bin_in = 20'd77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    done_cnt = 0;
    while (!bus.done && cyc < 3 * LAT) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.done) done_cnt++;
    checks++;
    if (done_cnt !== 1 || cyc !== LAT + 1 || bus.bcd_out !== 24'h000077) begin
      failures++;
      $display("[TB] FAIL back_to_back: done after %0d bcd=%h expected %0d/000077", cyc, bus.bcd_out, LAT + 1);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    logic [23:0] bcd; logic ovf; int lat, bc; bit to;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.bin_in = 20'd555555;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.overflow} !== 3'b000 || bus.bcd_out !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid: busy=%b done=%b ovf=%b bcd=%h expected all zero",
               bus.busy, bus.done, bus.overflow, bus.bcd_out);
    end
    // Start together with reset: reset wins.
    bus.start = 1'b1; bus.bin_in = 20'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_beats_start: busy=%b expected 0", bus.busy);
    end
    rst = 1'b0;
    done_cnt = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL no_done_after_abort: saw %0d busy/done cycles expected 0", done_cnt);
    end
    run_conv(20'd314159, bcd, ovf, lat, bc, to);
    checks++;
    if (to || bcd !== 24'h314159 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset_conv: bcd=%h ovf=%b expected 314159/0", bcd, ovf);
    end
  endtask

  task automatic test_sweep();
    int unsigned vals[$];
    logic [23:0] bcd; logic ovf; int lat, bc; bit to;
    bit bad_digit;
    for (int unsigned v = 0; v < 200; v++) vals.push_back(v);
    for (int unsigned v = 200; v < 10000; v += 13) vals.push_back(v);
    for (int i = 0; i < 1000; i++) vals.push_back($urandom_range(1048575, 0));
    foreach (vals[i]) begin
      run_conv(BIN_W'(vals[i]), bcd, ovf, lat, bc, to);
      bad_digit = 1'b0;
      for (int k = 0; k < DIGITS; k++)
        if (bcd[4*k +: 4] > 4'd9) bad_digit = 1'b1;
      checks++;
      if (to || bad_digit || lat !== LAT || bcd !== ref_bcd(vals[i]) || ovf !== ref_ovf(vals[i])) begin
        failures++;
        $display("[TB] FAIL sweep_%0d: bcd=%h ovf=%b lat=%0d expected %h/%b/%0d",
                 vals[i], bcd, ovf, lat, ref_bcd(vals[i]), ref_ovf(vals[i]), LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
